// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter
// Purpose  : Round-robin burst arbiter sharing one DRAM controller port
//            between the key/SBOX init writer (port 0) and the AES engine.
// Revision : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
  parameter int READ_LAT   = 2,
  parameter int TURNAROUND = 1,
  parameter int MAX_BURST  = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [5:0]  ADDR0,
  input  logic [5:0]  ADDR1,
  input  logic [63:0] WDATA0,
  input  logic [63:0] WDATA1,
  input  logic        LAST0,
  input  logic        LAST1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic [63:0] RDATA,
  output logic        IO_EN,
  output logic        WE,
  output logic [5:0]  ADDR,
  output logic [63:0] WBL_DATA,
  input  logic [63:0] RBL_DATA
);

  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0]  BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [TURN_W-1:0] TURN_LAST  = TURN_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TURN   = 2'd1;
  localparam logic [1:0] GRANT0 = 2'd2;
  localparam logic [1:0] GRANT1 = 2'd3;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              last_owner;
  logic              last_owner_valid;
  logic              winner;
  logic              turn_owner;
  logic [CNT_W-1:0]  beat_cnt;
  logic [TURN_W-1:0] turn_cnt;
  logic              accept;
  logic              acc_we;
  logic              acc_last;
  logic              release_grant;
  logic [5:0]        acc_addr;
  logic [63:0]       acc_wdata;
  logic [READ_LAT:0] rd_valid;
  logic [READ_LAT:0] rd_port;

  // Only one grant is ever active, so GNT1 alone selects the beat source.
  always_comb begin
    accept        = (GNT0 && REQ0) || (GNT1 && REQ1);
    acc_we        = GNT1 ? WE1    : WE0;
    acc_last      = GNT1 ? LAST1  : LAST0;
    acc_addr      = GNT1 ? ADDR1  : ADDR0;
    acc_wdata     = GNT1 ? WDATA1 : WDATA0;
    release_grant = accept && (acc_last || (beat_cnt == BURST_LAST));
  end

  // Prefer the port that did not own last; port 0 wins ties after reset.
  always_comb begin
    winner = (!last_owner_valid || last_owner) ? !REQ0 : REQ1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          if (!last_owner_valid || (winner == last_owner) || (TURNAROUND == 0))
            next_state = winner ? GRANT1 : GRANT0;
          else
            next_state = TURN;
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) next_state = turn_owner ? GRANT1 : GRANT0;
      end
      GRANT0, GRANT1: begin
        if (release_grant) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    GNT0 = (state == GRANT0);
    GNT1 = (state == GRANT1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_owner       <= 1'b0;
      last_owner_valid <= 1'b0;
      turn_owner       <= 1'b0;
      turn_cnt         <= '0;
      beat_cnt         <= '0;
    end else begin
      if (release_grant) begin
        last_owner       <= GNT1;
        last_owner_valid <= 1'b1;
      end
      if (state == IDLE) turn_owner <= winner;
      turn_cnt <= (state == TURN) ? turn_cnt + 1'b1 : '0;
      if (!(GNT0 || GNT1))
        beat_cnt <= '0;
      else if (accept && (beat_cnt != BURST_MAX))
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Read pipe tracks {valid, port} so returns survive ownership changes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IO_EN    <= 1'b0;
      WE       <= 1'b0;
      ADDR     <= '0;
      WBL_DATA <= '0;
      rd_valid <= '0;
      rd_port  <= '0;
      RVALID0  <= 1'b0;
      RVALID1  <= 1'b0;
      RDATA    <= '0;
    end else begin
      IO_EN <= accept;
      WE    <= accept && acc_we;
      if (accept) begin
        ADDR     <= acc_addr;
        WBL_DATA <= acc_wdata;
      end
      rd_valid <= {rd_valid[READ_LAT-1:0], accept && !acc_we};
      rd_port  <= {rd_port[READ_LAT-1:0], GNT1};
      RVALID0  <= rd_valid[READ_LAT] && !rd_port[READ_LAT];
      RVALID1  <= rd_valid[READ_LAT] &&  rd_port[READ_LAT];
      if (rd_valid[READ_LAT]) RDATA <= RBL_DATA;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_port_arbiter
// Purpose  : Directed vector table plus hand sequences for dram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

  localparam logic [63:0] DFLT = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] RB1  = 64'hDEADBEEF_01234567;
  localparam logic [63:0] RB2  = 64'h01234567_89ABCDEF;
  localparam logic [63:0] RB3  = 64'hCAFEF00D_00000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        last0 = 1'b0, last1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [63:0] wdata0 = '0, wdata1 = '0, rbl = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, io_en, we;
  logic [63:0] rdata, wbl_data;
  logic [5:0]  addr;

  int checks = 0;
  int errors = 0;
  logic       e_io;
  logic [5:0] e_addr;

  typedef struct {
    logic        rst;
    logic        req0, we0, last0, req1, we1, last1;
    logic [5:0]  addr0, addr1;
    logic [63:0] rbl;
    logic        e_gnt0, e_gnt1, e_io, e_we, e_rv0, e_rv1;
    logic [5:0]  e_addr;
    logic [63:0] e_wbl, e_rdata;
  } vec_t;

  vec_t vecs[20];

  dram_port_arbiter dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .LAST0(last0), .LAST1(last1),
    .GNT0(gnt0), .GNT1(gnt1), .RVALID0(rvalid0), .RVALID1(rvalid1),
    .RDATA(rdata), .IO_EN(io_en), .WE(we), .ADDR(addr),
    .WBL_DATA(wbl_data), .RBL_DATA(rbl)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic q0, input logic w0, input logic [5:0] a0, input logic l0,
    input logic q1, input logic w1, input logic [5:0] a1, input logic l1, input logic [63:0] rb,
    input logic g0, input logic g1, input logic io, input logic ew, input logic [5:0] ea,
    input logic [63:0] ewbl, input logic rv0, input logic rv1, input logic [63:0] erd);
    vec_t v;
    v.rst = r; v.req0 = q0; v.we0 = w0; v.addr0 = a0; v.last0 = l0;
    v.req1 = q1; v.we1 = w1; v.addr1 = a1; v.last1 = l1; v.rbl = rb;
    v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_io = io; v.e_we = ew; v.e_addr = ea;
    v.e_wbl = ewbl; v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rdata = erd;
    return v;
  endfunction

  task automatic set_p0(input logic r, input logic w, input logic [5:0] a, input logic l);
    req0 = r; we0 = w; addr0 = a; last0 = l;
    wdata0 = 64'h1000 + {58'd0, a};
  endtask

  task automatic set_p1(input logic r, input logic w, input logic [5:0] a, input logic l);
    req1 = r; we1 = w; addr1 = a; last1 = l;
    wdata1 = 64'h2000 + {58'd0, a};
  endtask

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Port 0 write burst, handover to port 1 read, round robin, read returns.
    vecs[0]  = mk(1, 0,0,0,0, 0,0,0,0, DFLT, 0,0,0,0,0,64'h0,    0,0,64'h0);
    vecs[1]  = mk(1, 0,0,0,0, 0,0,0,0, DFLT, 0,0,0,0,0,64'h0,    0,0,64'h0);
    vecs[2]  = mk(0, 1,1,0,0, 1,0,5,1, DFLT, 0,0,0,0,0,64'h0,    0,0,64'h0);
    vecs[3]  = mk(0, 1,1,0,0, 1,0,5,1, DFLT, 1,0,0,0,0,64'h0,    0,0,64'h0);
    vecs[4]  = mk(0, 1,1,1,0, 1,0,5,1, DFLT, 1,0,1,1,0,64'h1000, 0,0,64'h0);
    vecs[5]  = mk(0, 1,1,2,1, 1,0,5,1, DFLT, 1,0,1,1,1,64'h1001, 0,0,64'h0);
    vecs[6]  = mk(0, 0,0,0,0, 1,0,5,1, DFLT, 0,0,1,1,2,64'h1002, 0,0,64'h0);
    vecs[7]  = mk(0, 0,0,0,0, 1,0,5,1, DFLT, 0,0,0,0,2,64'h1002, 0,0,64'h0);
    vecs[8]  = mk(0, 1,1,9,1, 1,0,5,1, DFLT, 0,1,0,0,2,64'h1002, 0,0,64'h0);
    vecs[9]  = mk(0, 1,1,9,1, 1,0,5,1, DFLT, 0,0,1,0,5,64'h2005, 0,0,64'h0);
    vecs[10] = mk(0, 1,1,9,1, 1,0,5,1, DFLT, 0,0,0,0,5,64'h2005, 0,0,64'h0);
    vecs[11] = mk(0, 1,1,9,1, 1,0,7,1, RB1,  1,0,0,0,5,64'h2005, 0,0,64'h0);
    vecs[12] = mk(0, 0,0,0,0, 1,0,7,1, DFLT, 0,0,1,1,9,64'h1009, 0,1,RB1);
    vecs[13] = mk(0, 0,0,0,0, 1,0,7,1, DFLT, 0,0,0,0,9,64'h1009, 0,0,RB1);
    vecs[14] = mk(0, 0,0,0,0, 1,0,7,1, DFLT, 0,1,0,0,9,64'h1009, 0,0,RB1);
    vecs[15] = mk(0, 0,0,0,0, 0,0,0,0, DFLT, 0,0,1,0,7,64'h2007, 0,0,RB1);
    vecs[16] = mk(0, 0,0,0,0, 0,0,0,0, DFLT, 0,0,0,0,7,64'h2007, 0,0,RB1);
    vecs[17] = mk(0, 0,0,0,0, 0,0,0,0, RB2,  0,0,0,0,7,64'h2007, 0,0,RB1);
    vecs[18] = mk(0, 0,0,0,0, 0,0,0,0, DFLT, 0,0,0,0,7,64'h2007, 0,1,RB2);
    vecs[19] = mk(0, 0,0,0,0, 0,0,0,0, DFLT, 0,0,0,0,7,64'h2007, 0,0,RB2);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      set_p0(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].last0);
      set_p1(vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].last1);
      rbl = vecs[i].rbl;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {gnt0, gnt1, io_en, we, rvalid0, rvalid1, addr, wbl_data, rdata},
            {vecs[i].e_gnt0, vecs[i].e_gnt1, vecs[i].e_io, vecs[i].e_we,
             vecs[i].e_rv0, vecs[i].e_rv1, vecs[i].e_addr, vecs[i].e_wbl, vecs[i].e_rdata});
    end

    // Forced release: port 0 never raises LAST, port 1 waits behind it.
    for (int c = 0; c <= 37; c++) begin
      @(posedge clk); #1;
      set_p0(c <= 36, 1'b1, (c >= 2) ? 6'(c - 2) : 6'd0, 1'b0);
      set_p1(c <= 36, 1'b1, 6'd3, 1'b1);
      rbl = DFLT;
      @(negedge clk);
      e_io   = (c >= 3 && c <= 34) || (c == 37);
      e_addr = (c == 37) ? 6'd3 : (e_io ? 6'(c - 3) : 6'd0);
      check($sformatf("maxburst_c%0d", c),
            {gnt0, gnt1, io_en, e_io ? addr : 6'd0},
            {(c >= 2 && c <= 33), (c == 36), e_io, e_addr});
    end

    // Same-owner regrant: two port 0 bursts separated by a single idle cycle.
    for (int q = 0; q <= 7; q++) begin
      @(posedge clk); #1;
      set_p0(q <= 6, 1'b1, 6'(q), (q == 3) || (q == 6));
      set_p1(1'b0, 1'b0, 6'd0, 1'b0);
      @(negedge clk);
      check($sformatf("regrant_q%0d", q), {gnt0, gnt1, io_en},
            {(q == 2 || q == 3 || q == 5 || q == 6), 1'b0, (q == 3 || q == 4 || q == 6 || q == 7)});
    end

    // Mid-operation reset with port 1 granted and reads in flight.
    for (int r = 0; r <= 3; r++) begin
      @(posedge clk); #1;
      set_p0(1'b0, 1'b0, 6'd0, 1'b0);
      set_p1(1'b1, 1'b0, 6'(20 + r), 1'b0);
      @(negedge clk);
      check($sformatf("prerst_r%0d", r), {gnt0, gnt1, io_en}, {1'b0, (r >= 2), (r == 3)});
    end
    #1 rst = 1'b1;
    #1;
    check("rst_ctrl", {gnt0, gnt1, rvalid0, rvalid1, io_en, we}, 6'b0);
    check("rst_addr_wbl", {addr, wbl_data}, 70'b0);
    check("rst_rdata", rdata, 64'b0);
    for (int r = 4; r <= 9; r++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      set_p1(r <= 5, 1'b0, 6'd33, 1'b1);
      rbl = (r == 8) ? RB3 : DFLT;
      @(negedge clk);
      check($sformatf("postrst_r%0d", r),
            {gnt0, gnt1, io_en, rvalid0, rvalid1, (r == 6) ? addr : 6'd0, (r == 9) ? rdata : 64'd0},
            {1'b0, (r == 5), (r == 6), 1'b0, (r == 9), (r == 6) ? 6'd33 : 6'd0, (r == 9) ? RB3 : 64'd0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Shares the single 16-core DRAM controller port between two requesters: port 0, the key/SBOX init writer, and port 1, the AES round engine, which reads round keys and SBOX words and may also write. Ownership is granted per burst with round-robin fairness, a bus-handover gap, and a forced release after a maximum burst length. Read data is returned to the port that issued the read. The block sits directly in front of the DRAM controller. The top level broadcasts its WBL_DATA to all 16 cores' WBL_DATA1..16.

## Interface
- READ_LAT, 2: cycles from IO_EN beat to valid RBL_DATA (≥1)
- TURNAROUND, 1: idle cycles inserted when ownership changes (0 allowed)
- MAX_BURST, 32: accepted beats after which the grant is force-released (≥1)

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ0 / REQ1  in  1  port request; beat valid
- WE0 / WE1  in  1  1 = write beat, 0 = read beat
- ADDR0 / ADDR1  in  6  DRAM row address
- WDATA0 / WDATA1  in  64  write data
- LAST0 / LAST1  in  1  final beat of burst
- GNT0 / GNT1  out  1  registered; port owns the DRAM port
- RVALID0 / RVALID1  out  1  read data valid for that port
- RDATA  out  64  registered read data, shared by both ports
- IO_EN  out  1  registered DRAM beat strobe
- WE  out  1  registered write enable to controller
- ADDR  out  6  registered address to controller
- WBL_DATA  out  64  registered write data
- RBL_DATA  in  64  controller read data

## Operation
- Beat accepted on cycle t when REQx && GNTx. At t+1: IO_EN=1, and WE, ADDR, WBL_DATA take the port's values. Otherwise IO_EN=0 and WE=0; ADDR and WBL_DATA hold.
- FSM states: IDLE, TURN, GRANT0, GRANT1.
- IDLE: no REQ → stay. Otherwise pick a winner:
  - Prefer the port that is not last_owner if it requests, else the requesting port.
  - If last_owner_valid=0 (after reset), port 0 wins ties.
- IDLE to next state:
  - Go to GRANTw if winner == last_owner, or last_owner_valid=0, or TURNAROUND=0.
  - Otherwise go to TURN and count TURNAROUND cycles, then go to GRANTw. The winner is latched on entering TURN.
- GRANTx: GNTx=1 and the grant is locked. Deasserting REQx does not release it.
- Release to IDLE on the cycle after a beat is accepted with LASTx=1, or after the MAX_BURST-th accepted beat of the grant. On release, last_owner=x and last_owner_valid=1.
- Beat counter: clears on grant entry, increments per accepted beat, width ≥ clog2(MAX_BURST+1), never wraps.
- Read return: a READ_LAT+1-deep pipe carries {valid, port} for each read beat.
  - RBL_DATA is sampled into RDATA READ_LAT cycles after IO_EN.
  - RVALIDx pulses with RDATA, one cycle after the sample.
  - Read returns are independent of current ownership; in-flight reads still return after a grant changes hands.
- Write beats produce no RVALID.
- TURN while REQ of the latched winner has dropped: still enter GRANTw. The grant is held until LAST or MAX_BURST.

## Timing
- Reset values: GNT0=GNT1=0, RVALID0=RVALID1=0, RDATA=0, IO_EN=0, WE=0, ADDR=0, WBL_DATA=0.
- Reset internals: state IDLE, last_owner_valid=0, beat count 0, read pipe flushed.
- RST mid-operation: all outputs go to reset values immediately. In-flight reads are discarded and never raise RVALID.
- Request latency, from REQ in IDLE to GNT:
  - 1 cycle with no gap (first grant, same owner, or TURNAROUND=0).
  - 1+TURNAROUND cycles when ownership changes.
- Release latency: LAST accepted at t gives GNT=0 at t+1 (IDLE at t+1).
- Read latency: read accepted at t gives IO_EN at t+1, RBL_DATA sampled at t+1+READ_LAT, RVALIDx at t+2+READ_LAT.
- Back-to-back beats: one per cycle while granted and REQ high.

## Test plan
- Reset priority and handover:
  - Stimulus: from reset, REQ0 and REQ1 high at cycle 0; port 0 writes addr 0,1,2 with LAST on addr 2.
  - Response: GNT0 high cycles 1–3; IO_EN high cycles 2–4 with ADDR 0,1,2 and WE=1; GNT0 low cycle 4; TURN cycle 5; GNT1 high cycle 6.
- Round robin:
  - Stimulus: after port 1 finishes a 1-beat burst, both REQ high.
  - Response: port 0 is granted next, not port 1.
- Read return, READ_LAT=2:
  - Stimulus: port 1 reads addr 5 at cycle t; RBL_DATA=64'hDEADBEEF_01234567 at t+3.
  - Response: RVALID1=1 and RDATA=that value at t+4; RVALID0 stays 0.
- Forced release, MAX_BURST=32:
  - Stimulus: port 0 streams 40 beats with LAST never asserted.
  - Response: GNT0 drops after the 32nd accepted beat; port 1 is granted after the turnaround.
- Same-owner regrant:
  - Stimulus: only REQ0 active; two consecutive bursts.
  - Response: one IDLE cycle between bursts, no TURN cycle.
- Mid-operation reset:
  - Stimulus: RST pulsed while a read is in the pipe and GNT1=1.
  - Response: all outputs 0 immediately; no RVALID afterwards; after release, REQ1 alone is granted at +1 cycle.
